// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its neighbours: instruction-memory
// req/ack, the issue valid/ready handshake, the redirect inputs and the status flags.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr_out;
  logic [3:0]        opcode;
  logic [2:0]        funct;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus1;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halted;
  logic              fetch_err;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr_out, opcode, funct, pc_out, pc_plus1,
    input  redirect_valid, redirect_addr,
    output halted, fetch_err
  );

  // Memory / decoder side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr_out, opcode, funct, pc_out, pc_plus1,
    output redirect_valid, redirect_addr,
    input  halted, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words over req/ack,
// holds them in the instruction register and issues them with valid/ready.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'hF,
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StFetch, StIssue, StHalted} state_e;

  localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [15:0]       ir_q, ir_d;

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be >= 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

  // Counts ack-less FETCH cycles; TIMEOUT_CYC-1 is the last value before giving up.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Next-state logic for the fetch/issue/halt sequence.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StFetch: begin
        if (bus.imem_ack) begin
          ir_d     = bus.imem_rdata;
          pc_out_d = pc_q;
          state_d  = StIssue;
`ifdef FETCH_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          state_d = StHalted;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
`endif
        end
      end
      StIssue: begin
        if (bus.instr_ready) begin
          if (ir_q[15:12] == HALT_OPCODE) begin
            state_d = StHalted;
          end else begin
            pc_d    = bus.redirect_valid ? bus.redirect_addr : pc_q + PcOne;
            state_d = StFetch;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      ir_q     <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs decoded from state; request is suppressed while reset is held.
  always_comb begin
    bus.imem_req    = (state_q == StFetch) && !rst;
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == StIssue);
    bus.instr_out   = ir_q;
    bus.opcode      = ir_q[15:12];
    bus.funct       = ir_q[2:0];
    bus.pc_out      = pc_out_q;
    bus.pc_plus1    = pc_out_q + PcOne;
    bus.halted      = (state_q == StHalted);
`ifdef FETCH_TIMEOUT_EN
    bus.fetch_err   = err_q;
`else
    bus.fetch_err   = 1'b0;
`endif
  end

endmodule
